decode_cycle: RTL and testbench
===============================

# decode_cycle

Instruction-decode stage of the five-stage RV32I pipeline, directly upstream of the execute stage. Takes the fetched instruction and PC values from the IF/ID register, decodes control, reads the 32×32 register file and sign-extends the immediate. Registers everything into the ID/EX pipeline register that feeds execute. Also hosts the register-file write port driven from writeback, and supports an execute-stage flush for hazard handling.

## Interface
Parameters:
- none; widths are fixed by the ISA (XLEN 32, 32 registers).

Ports:
- clk  in  1  stage clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback write enable
- RDW  in  5  writeback destination register
- ResultW  in  32  writeback data
- FlushE  in  1  turn the next ID/EX contents into a bubble
- RS1D, RS2D  out  5  combinational source indices (InstrD[19:15], [24:20]) for the hazard unit
- RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  out  1  registered control
- ALUControlE  out  3  registered ALU operation
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32  registered data
- RDE, RS1E, RS2E  out  5  registered register indices

## Operation
- Decoded opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011; any other opcode decodes as NOP (all control 0, ImmExt 0).
- Control per opcode (RegWrite/ResultSrc/MemWrite/Branch/ALUSrc):
  - lw 1/1/0/0/1
  - sw 0/0/1/0/1
  - R 1/0/0/0/0
  - I-ALU 1/0/0/0/1
  - beq 0/0/0/1/0
- ALUControl encoding: add 000, sub 001, and 010, or 011, slt 101.
  - lw/sw → add; beq → sub.
  - R/I by funct3:
    - 000 → add, except sub when R-type and funct7[5]=1
    - 010 → slt
    - 110 → or
    - 111 → and
    - other funct3 → add
- Immediates, sign-extended from bit 31:
  - I: Instr[31:20]
  - S: {Instr[31:25], Instr[11:7]}
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}
  - R-type: 0
- Register file: two combinational read ports, one write port.
  - Write on rising clk when RegWriteW=1 and RDW≠0.
  - x0 always reads 0 and is never written.
- Write-through bypass: if RegWriteW=1, RDW≠0 and RDW equals a read index, that port returns ResultW in the same cycle.
- ID/EX register: on each rising edge captures all decoded control, RD1/RD2 (post-bypass), ImmExt, PCD, PCPlus4D, and rd/rs1/rs2 (Instr[11:7], [19:15], [24:20]).
- FlushE=1 at a rising edge loads every ID/EX field with 0 (NOP bubble). Register-file writes still occur that cycle.

## Timing
- Latency: 1 cycle, InstrD → E outputs.
- RS1D/RS2D are combinational, zero latency.
- Reset (asynchronous, immediate):
  - all E outputs 0
  - all 32 registers 0
  - holds while rst=1
- Writeback write in cycle N is visible:
  - to a decode read in cycle N, via the bypass
  - from the array in cycle N+1 onward
- Simultaneous cases:
  - FlushE with a valid instruction: flush wins.
  - Write to x0 with bypass match: read still 0.
- rst deassertion: first capture at the next rising edge.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants
  - ALUControl encodings
  - ImmSrc enum (I, S, B, NONE)
  - XLEN=32
- One sub-module: register_file.
  - Ports: clk, rst, A1, A2, A3, WE3, WD3, RD1, RD2.
  - Contains the array, the x0 rule and the bypass.
- Control decode and immediate extend are inline logic in decode_cycle.

## Test plan
- Reset: assert rst mid-run → all E outputs and registers read 0 immediately. After release, `add x3,x0,x0` yields RD1E=RD2E=0.
- `addi x5,x0,-3` (0xFFD00293) → next cycle:
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000
  - ImmExtE=0xFFFFFFFD, RDE=5
- `sw x2,8(x1)` then `beq x1,x2,-4` → first instruction:
  - MemWriteE=1, ImmExtE=8
  - then BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC
- Bypass: RegWriteW=1, RDW=7, ResultW=0xDEADBEEF while decoding `sub x1,x7,x7` → RD1E=RD2E=0xDEADBEEF, ALUControlE=001.
- x0 protection: RegWriteW=1, RDW=0, ResultW=0x1234 with `or x4,x0,x0` → RD1E=RD2E=0, and x0 stays 0 afterward.
- Flush: FlushE=1 while decoding `lw x9,0(x2)` → all E outputs 0 next cycle. With FlushE=0 the following cycle, the next instruction passes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the pipeline stages. It holds the opcode
// constants, the ALUControl encodings, the immediate-source enum and the
// packed control and ID/EX records. It also holds the immediate sign-extend
// helper.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_NONE
  } imm_src_e;

  typedef struct packed {
    logic      reg_write;
    logic      result_src;
    logic      mem_write;
    logic      branch;
    logic      alu_src;
    alu_ctrl_e alu_control;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
  } idex_t;

  // Only bits [31:7] of an instruction carry immediate data.
  function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] instr,
                                                  input imm_src_e   src);
    logic [XLEN-1:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// This is a 32 x 32 register file with two combinational read ports and one
// write port. The write port is driven from writeback. Register x0 is
// hard-wired to zero. A write in flight is bypassed to a matching read port
// in the same cycle.
//   clk, rst  : clock and asynchronous active-high reset (clears all entries)
//   A1, A2    : read indices          RD1, RD2 : read data (post-bypass)
//   A3        : write index           WD3      : write data
//   WE3       : write enable (ignored when A3 == 0)
// ---------------------------------------------------------------------------
module register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [XLEN-1:0] regs_q [NREGS];

  // NOTE: the array is reset, because the pipeline must observe all-zero
  // registers right after rst. That rules out a plain RAM macro here.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (WE3 && (A3 != 5'd0)) begin
      regs_q[A3] <= WD3;
    end
  end

  // The x0 test comes first, so a bypass match on x0 still reads zero.
  always_comb begin
    if (A1 == 5'd0)                RD1 = '0;
    else if (WE3 && (A3 == A1))    RD1 = WD3;
    else                           RD1 = regs_q[A1];

    if (A2 == 5'd0)                RD2 = '0;
    else if (WE3 && (A3 == A2))    RD2 = WD3;
    else                           RD2 = regs_q[A2];
  end

endmodule

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
// This is the RV32I instruction-decode stage. It decodes control, reads the
// register file and sign-extends the immediate. All of this is registered
// into the ID/EX pipeline register. FlushE turns the next ID/EX contents
// into a bubble.
//   InstrD, PCD, PCPlus4D        : from IF/ID
//   RegWriteW, RDW, ResultW      : writeback write port
//   FlushE                       : load a NOP bubble into ID/EX
//   RS1D, RS2D                   : combinational source indices (hazard unit)
//   RegWriteE .. ALUControlE     : registered control
//   RD1E, RD2E, ImmExtE, PCE,
//   PCPlus4E, RDE, RS1E, RS2E    : registered data and indices
// ---------------------------------------------------------------------------
module decode_cycle
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      RS1D,
  output logic [4:0]      RS2D,
  output logic            RegWriteE,
  output logic            ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RDE,
  output logic [4:0]      RS1E,
  output logic [4:0]      RS2E
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  alu_ctrl_e       alu_rt;
  ctrl_t           ctrl_d;
  imm_src_e        imm_src;
  logic [XLEN-1:0] rd1, rd2;
  idex_t           idex_d, idex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign RS1D   = InstrD[19:15];
  assign RS2D   = InstrD[24:20];

  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    alu_rt  = ALU_ADD;
    ctrl_d  = '0;
    imm_src = IMM_NONE;

    // R-type and I-ALU share the funct3 map. Only R-type uses funct7[5] for sub.
    case (funct3)
      3'b000:  alu_rt = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_rt = ALU_SLT;
      3'b110:  alu_rt = ALU_OR;
      3'b111:  alu_rt = ALU_AND;
      default: alu_rt = ALU_ADD;
    endcase

    case (opcode)
      OP_LW: begin
        ctrl_d  = '{reg_write: 1'b1, result_src: 1'b1, mem_write: 1'b0,
                    branch: 1'b0, alu_src: 1'b1, alu_control: ALU_ADD};
        imm_src = IMM_I;
      end
      OP_SW: begin
        ctrl_d  = '{reg_write: 1'b0, result_src: 1'b0, mem_write: 1'b1,
                    branch: 1'b0, alu_src: 1'b1, alu_control: ALU_ADD};
        imm_src = IMM_S;
      end
      OP_R: begin
        ctrl_d  = '{reg_write: 1'b1, result_src: 1'b0, mem_write: 1'b0,
                    branch: 1'b0, alu_src: 1'b0, alu_control: alu_rt};
        imm_src = IMM_NONE;
      end
      OP_I: begin
        ctrl_d  = '{reg_write: 1'b1, result_src: 1'b0, mem_write: 1'b0,
                    branch: 1'b0, alu_src: 1'b1, alu_control: alu_rt};
        imm_src = IMM_I;
      end
      OP_BEQ: begin
        ctrl_d  = '{reg_write: 1'b0, result_src: 1'b0, mem_write: 1'b0,
                    branch: 1'b1, alu_src: 1'b0, alu_control: ALU_SUB};
        imm_src = IMM_B;
      end
      default: begin
        ctrl_d  = '0;
        imm_src = IMM_NONE;
      end
    endcase
  end

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .A1  (RS1D),
    .A2  (RS2D),
    .A3  (RDW),
    .WE3 (RegWriteW),
    .WD3 (ResultW),
    .RD1 (rd1),
    .RD2 (rd2)
  );

  assign idex_d = '{ctrl:     ctrl_d,
                    rd1:      rd1,
                    rd2:      rd2,
                    imm_ext:  imm_extend(InstrD[31:7], imm_src),
                    pc:       PCD,
                    pc_plus4: PCPlus4D,
                    rd:       InstrD[11:7],
                    rs1:      InstrD[19:15],
                    rs2:      InstrD[24:20]};

  // Flush has priority over a valid instruction. Register-file writes are
  // unaffected by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idex_q <= '0;
    else if (FlushE) idex_q <= '0;
    else             idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign ALUControlE = idex_q.ctrl.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RDE         = idex_q.rd;
  assign RS1E        = idex_q.rs1;
  assign RS2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
// Self-checking bench for decode_cycle. A behavioural model computes the
// expected ID/EX contents from the instruction fields with plain arithmetic.
// It uses a 32-entry array for the register file. A compare process checks
// every ID/EX output on each falling edge. Directed instructions add literal
// expectations on top of the randomized traffic.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic [4:0]  RS1D, RS2D;
  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RDE, RS1E, RS2E;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .RS1D        (RS1D),
    .RS2D        (RS2D),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RDE         (RDE),
    .RS1E        (RS1E),
    .RS2E        (RS2E)
  );

  typedef struct {
    logic        rw, rsrc, mw, br, asrc;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } e_t;

  e_t          exp_e;
  e_t          zero_e;
  logic [31:0] mregs [32];
  int          n_checks = 0;
  int          n_err    = 0;
  bit          chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference read: x0 is zero, an in-flight write is forwarded, and
  // otherwise the value comes from the array.
  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return mregs[idx];
  endfunction

  function automatic e_t model(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] pc4, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic flush);
    e_t         e;
    int         imm_i, imm_s, imm_b;
    logic [2:0] alu_rt;
    logic [6:0] op;
    e = '{default: '0};
    if (flush) return e;
    op    = instr[6:0];
    imm_i = int'(instr[30:20]) - (instr[31] ? 2048 : 0);
    imm_s = int'(instr[11:7]) + 32 * int'(instr[30:25]) - (instr[31] ? 2048 : 0);
    imm_b = 2 * int'(instr[11:8]) + 32 * int'(instr[30:25]) + 2048 * int'(instr[7])
            - (instr[31] ? 4096 : 0);
    case (instr[14:12])
      3'b000:  alu_rt = (op == 7'b0110011 && instr[30]) ? 3'd1 : 3'd0;
      3'b010:  alu_rt = 3'd5;
      3'b110:  alu_rt = 3'd3;
      3'b111:  alu_rt = 3'd2;
      default: alu_rt = 3'd0;
    endcase
    case (op)
      7'b0000011: begin {e.rw, e.rsrc, e.mw, e.br, e.asrc} = 5'b11001; e.alu = 3'd0;   e.imm = imm_i; end
      7'b0100011: begin {e.rw, e.rsrc, e.mw, e.br, e.asrc} = 5'b00101; e.alu = 3'd0;   e.imm = imm_s; end
      7'b0110011: begin {e.rw, e.rsrc, e.mw, e.br, e.asrc} = 5'b10000; e.alu = alu_rt; e.imm = 32'd0; end
      7'b0010011: begin {e.rw, e.rsrc, e.mw, e.br, e.asrc} = 5'b10001; e.alu = alu_rt; e.imm = imm_i; end
      7'b1100011: begin {e.rw, e.rsrc, e.mw, e.br, e.asrc} = 5'b00010; e.alu = 3'd1;   e.imm = imm_b; end
      default:    ;
    endcase
    e.rd1 = rd_model(instr[19:15], we, wa, wd);
    e.rd2 = rd_model(instr[24:20], we, wa, wd);
    e.pc  = pc;
    e.pc4 = pc4;
    e.rd  = instr[11:7];
    e.rs1 = instr[19:15];
    e.rs2 = instr[24:20];
    return e;
  endfunction

  task automatic compare_all();
    check("RegWriteE",   32'(RegWriteE),   32'(exp_e.rw));
    check("ResultSrcE",  32'(ResultSrcE),  32'(exp_e.rsrc));
    check("MemWriteE",   32'(MemWriteE),   32'(exp_e.mw));
    check("BranchE",     32'(BranchE),     32'(exp_e.br));
    check("ALUSrcE",     32'(ALUSrcE),     32'(exp_e.asrc));
    check("ALUControlE", 32'(ALUControlE), 32'(exp_e.alu));
    check("RD1E",        RD1E,             exp_e.rd1);
    check("RD2E",        RD2E,             exp_e.rd2);
    check("ImmExtE",     ImmExtE,          exp_e.imm);
    check("PCE",         PCE,              exp_e.pc);
    check("PCPlus4E",    PCPlus4E,         exp_e.pc4);
    check("RDE",         32'(RDE),         32'(exp_e.rd));
    check("RS1E",        32'(RS1E),        32'(exp_e.rs1));
    check("RS2E",        32'(RS2E),        32'(exp_e.rs2));
  endtask

  // The outputs are stable from the rising edge until here. Stimulus and
  // expectations change 1 ns after this edge.
  always @(negedge clk) if (chk_en) compare_all();

  task automatic step(input logic [31:0] instr, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic flush);
    logic [31:0] pc;
    @(negedge clk);
    #1;
    pc        = $urandom & 32'hFFFF_FFFC;
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    RegWriteW = we;
    RDW       = wa;
    ResultW   = wd;
    FlushE    = flush;
    exp_e     = model(instr, pc, pc + 32'd4, we, wa, wd, flush);
    if (we && wa != 5'd0) mregs[wa] = wd;
    #1;
    check("RS1D", 32'(RS1D), 32'(instr[19:15]));
    check("RS2D", 32'(RS2D), 32'(instr[24:20]));
    @(posedge clk);
    #2;
  endtask

  // Holds reset for two edges, then releases it mid-cycle. The next edge
  // captures the inputs that are still applied, against a cleared array.
  task automatic hold_and_release();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst   = 1'b0;
    exp_e = model(InstrD, PCD, PCPlus4D, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    RegWriteW = 1'b0;
    FlushE    = 1'b0;
    exp_e     = zero_e;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    #1;
    compare_all();
    hold_and_release();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111};
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 5)]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic [4:0]  wa;
    int          sel;
    zero_e    = '{default: '0};
    exp_e     = zero_e;
    rst       = 1'b1;
    InstrD    = 32'd0;
    PCD       = 32'd0;
    PCPlus4D  = 32'd0;
    RegWriteW = 1'b0;
    RDW       = 5'd0;
    ResultW   = 32'd0;
    FlushE    = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    #1;
    compare_all();
    chk_en = 1'b1;
    hold_and_release();

    // Randomized traffic: writes often target the decoded sources so the
    // bypass is exercised. x0 writes and flushes are mixed in.
    for (int n = 0; n < 300; n++) begin
      ins = rand_instr();
      sel = $urandom_range(0, 9);
      if (sel < 4)      wa = ins[19:15];
      else if (sel < 6) wa = ins[24:20];
      else if (sel < 7) wa = 5'd0;
      else              wa = 5'($urandom);
      step(ins, ($urandom_range(0, 3) != 0), wa, $urandom, ($urandom_range(0, 9) == 0));
    end

    // Reset in the middle of a run clears ID/EX and the whole array.
    step(32'h0000_0000, 1'b1, 5'd5, 32'h5555_0005, 1'b0);
    step(32'h0000_0000, 1'b1, 5'd6, 32'h6666_0006, 1'b0);
    assert_reset();
    step(32'h0062_81B3, 1'b0, 5'd0, 32'd0, 1'b0);              // add x3,x5,x6
    check("rst_rd1", RD1E, 32'd0);
    check("rst_rd2", RD2E, 32'd0);

    step(32'hFFD0_0293, 1'b0, 5'd0, 32'd0, 1'b0);              // addi x5,x0,-3
    check("addi_regwrite", 32'(RegWriteE), 32'd1);
    check("addi_alusrc",   32'(ALUSrcE),   32'd1);
    check("addi_alu",      32'(ALUControlE), 32'd0);
    check("addi_imm",      ImmExtE,        32'hFFFF_FFFD);
    check("addi_rd",       32'(RDE),       32'd5);

    step(32'h0020_A423, 1'b0, 5'd0, 32'd0, 1'b0);              // sw x2,8(x1)
    check("sw_memwrite", 32'(MemWriteE), 32'd1);
    check("sw_imm",      ImmExtE,        32'd8);
    step(32'hFE20_8EE3, 1'b0, 5'd0, 32'd0, 1'b0);              // beq x1,x2,-4
    check("beq_branch", 32'(BranchE),     32'd1);
    check("beq_alu",    32'(ALUControlE), 32'd1);
    check("beq_imm",    ImmExtE,          32'hFFFF_FFFC);

    step(32'h4073_80B3, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);      // sub x1,x7,x7
    check("byp_rd1", RD1E, 32'hDEAD_BEEF);
    check("byp_rd2", RD2E, 32'hDEAD_BEEF);
    check("byp_alu", 32'(ALUControlE), 32'd1);
    step(32'h0003_8133, 1'b0, 5'd0, 32'd0, 1'b0);              // add x2,x7,x0
    check("array_rd1", RD1E, 32'hDEAD_BEEF);

    step(32'h0000_6233, 1'b1, 5'd0, 32'h0000_1234, 1'b0);      // or x4,x0,x0
    check("x0_rd1", RD1E, 32'd0);
    check("x0_rd2", RD2E, 32'd0);
    check("x0_alu", 32'(ALUControlE), 32'd3);
    step(32'h0000_01B3, 1'b0, 5'd0, 32'd0, 1'b0);              // add x3,x0,x0
    check("x0_after", RD1E, 32'd0);

    step(32'h0001_2483, 1'b0, 5'd0, 32'd0, 1'b1);              // lw x9,0(x2), flushed
    check("flush_regwrite",  32'(RegWriteE),  32'd0);
    check("flush_resultsrc", 32'(ResultSrcE), 32'd0);
    check("flush_alusrc",    32'(ALUSrcE),    32'd0);
    check("flush_rd",        32'(RDE),        32'd0);
    check("flush_rs1",       32'(RS1E),       32'd0);
    check("flush_pc",        PCE,             32'd0);
    step(32'h0072_8313, 1'b0, 5'd0, 32'd0, 1'b0);              // addi x6,x5,7
    check("post_regwrite", 32'(RegWriteE), 32'd1);
    check("post_alusrc",   32'(ALUSrcE),   32'd1);
    check("post_imm",      ImmExtE,        32'd7);
    check("post_rd",       32'(RDE),       32'd6);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
